// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: clear-sequencer state
// encoding, address-width helper and the default geometry that the hazard
// unit also relies on.
package rf_pkg;

    // Default geometry of the architectural register file.
    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

    // Bulk-clear sequencer states.
    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Number of address bits needed for 'depth' entries (depth is a power of two).
    function automatic int rf_aw(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer. A CLR sample in IDLE starts a walk over every entry,
// issuing one clear write per cycle from entry 0 up to DEPTH-1. BUSY stays
// high for exactly DEPTH cycles; CLR is ignored while the walk is running.
// The current state is exported for observation.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = rf_aw(RF_DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output rf_state_t     state
);

    rf_state_t     state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_next;

    // State and counter registers; reset aborts any walk in progress.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter update and clear-port outputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        clr_we     = 1'b0;
        clr_addr   = cnt;
        case (state)
            RF_IDLE: begin
                if (clr) begin
                    state_next = RF_CLEAR;
                    cnt_next   = '0;
                end
            end
            RF_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // Terminating on the last entry means the counter never wraps.
                if (cnt == AW'(DEPTH - 1)) begin
                    state_next = RF_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = RF_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multi-port register file: NRD combinational read ports, NWR
// rising-edge write ports (higher port index wins on an address collision),
// optional hardwired-zero entry 0 and a sequenced bulk clear that blocks user
// writes while BUSY is high.
// Build option: define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NWR-1:0]       WE,
    input  logic [NWR*rf_aw(DEPTH)-1:0] WA,
    input  logic [NWR*WIDTH-1:0] WD,
    input  logic [NRD*rf_aw(DEPTH)-1:0] RA,
    output logic [NRD*WIDTH-1:0] RD,
    input  logic                 CLR,
    output logic                 BUSY
);

    localparam int AW = rf_aw(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    rf_state_t        clr_state;

    rf_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (CLR),
        .busy     (BUSY),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .state    (clr_state)
    );

    // Storage: async clear on reset, clear-walk writes, else user writes.
    // Ports are applied in ascending order so the highest index wins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (clr_state == RF_IDLE) begin
            for (int p = 0; p < NWR; p++) begin
                if (WE[p] && !((ZERO_REG != 0) && (WA[p*AW +: AW] == '0))) begin
                    mem[WA[p*AW +: AW]] <= WD[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;

        assign ra = RA[r*AW +: AW];

        // Read mux: stored value, zero entry masking and optional forwarding.
        always_comb begin
            rd = mem[ra];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end
`ifdef RF_BYPASS_EN
            // Forwarding only when the write would actually land this edge.
            else if (RST && !BUSY) begin
                for (int p = 0; p < NWR; p++) begin
                    if (WE[p] && (WA[p*AW +: AW] == ra)) begin
                        rd = WD[p*WIDTH +: WIDTH];
                    end
                end
            end
`endif
        end

        assign RD[r*WIDTH +: WIDTH] = rd;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed testbench for rf_multiport (2 read, 2 write ports, 32x32, zero reg).
module tb_rf_multiport;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                 clk;
    logic                 rst;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    wa;
    logic [NWR*WIDTH-1:0] wd;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic                 clr;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    rf_multiport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .WE   (we),
        .WA   (wa),
        .WD   (wd),
        .RA   (ra),
        .RD   (rd),
        .CLR  (clr),
        .BUSY (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drv_write(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        we[p]             = 1'b1;
        wa[p*AW +: AW]    = a;
        wd[p*WIDTH +: WIDTH] = d;
    endtask

    task automatic drv_idle();
        we = '0;
    endtask

    task automatic set_ra(input int r, input logic [AW-1:0] a);
        ra[r*AW +: AW] = a;
    endtask

    function automatic logic [WIDTH-1:0] rd_port(input int r);
        return rd[r*WIDTH +: WIDTH];
    endfunction

    task automatic test_reset();
        logic [WIDTH-1:0] exp;
        rst = 1'b0;
        clr = 1'b0;
        we  = '0;
        wa  = '0;
        wd  = '0;
        ra  = {5'd17, 5'd5};
        @(negedge clk);
        #1;
        n_checks++;
        if (rd_port(0) !== 32'h0) begin n_fail++; $display("FAIL reset_rd0 got %0h exp 0", rd_port(0)); end
        n_checks++;
        if (rd_port(1) !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %0h exp 0", rd_port(1)); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        drv_write(0, 5'd5, 32'hDEADBEEF);
        set_ra(0, 5'd5);
        #1;
        exp = BYP ? 32'hDEADBEEF : 32'h0;
        n_checks++;
        if (rd_port(0) !== exp) begin n_fail++; $display("FAIL first_write_same_cycle got %0h exp %0h", rd_port(0), exp); end
        @(negedge clk);
        drv_idle();
        #1;
        n_checks++;
        if (rd_port(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL first_write_next_cycle got %0h exp deadbeef", rd_port(0)); end
        // Asynchronous reset away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (rd_port(0) !== 32'h0) begin n_fail++; $display("FAIL async_reset_rd got %0h exp 0", rd_port(0)); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drv_write(0, 5'd0, 32'h1234);
        drv_write(1, 5'd0, 32'h5678);
        set_ra(0, 5'd0);
        #1;
        n_checks++;
        if (rd_port(0) !== 32'h0) begin n_fail++; $display("FAIL zero_reg_same_cycle got %0h exp 0", rd_port(0)); end
        @(negedge clk);
        drv_idle();
        #1;
        n_checks++;
        if (rd_port(0) !== 32'h0) begin n_fail++; $display("FAIL zero_reg_next_cycle got %0h exp 0", rd_port(0)); end
    endtask

    task automatic test_write_conflict();
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        drv_write(0, 5'd7, 32'hAAAA);
        drv_write(1, 5'd7, 32'h5555);
        set_ra(1, 5'd7);
        #1;
        exp = BYP ? 32'h5555 : 32'h0;
        n_checks++;
        if (rd_port(1) !== exp) begin n_fail++; $display("FAIL conflict_same_cycle got %0h exp %0h", rd_port(1), exp); end
        @(negedge clk);
        drv_idle();
        #1;
        n_checks++;
        if (rd_port(1) !== 32'h5555) begin n_fail++; $display("FAIL conflict_winner got %0h exp 5555", rd_port(1)); end
        @(negedge clk);
        drv_write(0, 5'd8, 32'h8888);
        drv_write(1, 5'd9, 32'h9999);
        @(negedge clk);
        drv_idle();
        set_ra(0, 5'd8);
        set_ra(1, 5'd9);
        #1;
        n_checks++;
        if (rd_port(0) !== 32'h8888) begin n_fail++; $display("FAIL dual_write_p0 got %0h exp 8888", rd_port(0)); end
        n_checks++;
        if (rd_port(1) !== 32'h9999) begin n_fail++; $display("FAIL dual_write_p1 got %0h exp 9999", rd_port(1)); end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        drv_write(0, 5'd9, 32'hCAFE);
        set_ra(0, 5'd9);
        set_ra(1, 5'd9);
        #1;
        exp = BYP ? 32'hCAFE : 32'h9999;
        n_checks++;
        if (rd_port(0) !== exp) begin n_fail++; $display("FAIL bypass_rd0 got %0h exp %0h", rd_port(0), exp); end
        n_checks++;
        if (rd_port(1) !== exp) begin n_fail++; $display("FAIL bypass_rd1 got %0h exp %0h", rd_port(1), exp); end
        @(negedge clk);
        drv_idle();
        #1;
        n_checks++;
        if (rd_port(0) !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_next_cycle got %0h exp cafe", rd_port(0)); end
    endtask

    task automatic test_clear();
        logic [WIDTH-1:0] exp;
        logic             exp_busy;
        // Fill every entry with 0x100 + index, two per cycle.
        for (int k = 0; k < DEPTH / 2; k++) begin
            @(negedge clk);
            drv_write(0, AW'(2 * k), 32'h100 + 32'(2 * k));
            drv_write(1, AW'(2 * k + 1), 32'h100 + 32'(2 * k + 1));
        end
        @(negedge clk);
        drv_idle();
        set_ra(0, 5'd31);
        set_ra(1, 5'd6);
        #1;
        n_checks++;
        if (rd_port(0) !== 32'h11F) begin n_fail++; $display("FAIL fill_31 got %0h exp 11f", rd_port(0)); end
        n_checks++;
        if (rd_port(1) !== 32'h106) begin n_fail++; $display("FAIL fill_6 got %0h exp 106", rd_port(1)); end
        // CLR together with a user write: that write still lands.
        @(negedge clk);
        clr = 1'b1;
        drv_write(0, 5'd20, 32'hBEEF);
        @(negedge clk);
        clr = 1'b0;
        drv_idle();
        set_ra(1, 5'd20);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_start got %0b exp 1", busy); end
        n_checks++;
        if (rd_port(1) !== 32'hBEEF) begin n_fail++; $display("FAIL clear_edge_write got %0h exp beef", rd_port(1)); end
        for (int n = 1; n <= DEPTH; n++) begin
            @(negedge clk);
            set_ra(0, AW'(n - 1));
            set_ra(1, AW'(n));
            if (n == 2) drv_write(0, 5'd3, 32'h3333);
            if (n == 3) drv_idle();
            if (n == 5) clr = 1'b1;
            if (n == 6) clr = 1'b0;
            #1;
            exp_busy = (n < DEPTH);
            n_checks++;
            if (busy !== exp_busy) begin n_fail++; $display("FAIL clear_busy n=%0d got %0b exp %0b", n, busy, exp_busy); end
            n_checks++;
            if (rd_port(0) !== 32'h0) begin n_fail++; $display("FAIL clear_entry_%0d got %0h exp 0", n - 1, rd_port(0)); end
            if (n < DEPTH) begin
                exp = (n == 20) ? 32'hBEEF : 32'h100 + 32'(n);
                n_checks++;
                if (rd_port(1) !== exp) begin n_fail++; $display("FAIL pending_entry_%0d got %0h exp %0h", n, rd_port(1), exp); end
            end
            if (n == DEPTH) drv_write(0, 5'd3, 32'h4444);
        end
        @(negedge clk);
        drv_idle();
        set_ra(0, 5'd3);
        #1;
        n_checks++;
        if (rd_port(0) !== 32'h4444) begin n_fail++; $display("FAIL write_after_clear got %0h exp 4444", rd_port(0)); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_not_requeued got %0b exp 0", busy); end
    endtask

    task automatic test_reset_mid_clear();
        int busy_cycles;
        @(negedge clk);
        drv_write(0, 5'd15, 32'h1515);
        drv_write(1, 5'd25, 32'h2525);
        @(negedge clk);
        drv_idle();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        set_ra(0, 5'd15);
        set_ra(1, 5'd25);
        #1;
        n_checks++;
        if (rd_port(0) !== 32'h1515) begin n_fail++; $display("FAIL mid_clear_pending got %0h exp 1515", rd_port(0)); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %0b exp 0", busy); end
        n_checks++;
        if (rd_port(0) !== 32'h0) begin n_fail++; $display("FAIL mid_reset_entry15 got %0h exp 0", rd_port(0)); end
        n_checks++;
        if (rd_port(1) !== 32'h0) begin n_fail++; $display("FAIL mid_reset_entry25 got %0h exp 0", rd_port(1)); end
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (busy_cycles !== DEPTH) begin n_fail++; $display("FAIL fresh_clear_length got %0d exp %0d", busy_cycles, DEPTH); end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_write_conflict();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised multi-port register file for the pipelined core. It replaces the fixed 2-read/1-write, negedge-write file. It provides NRD read ports and NWR write ports, an optional register-0-hardwired-zero mode, optional write-to-read bypass, and a sequenced bulk-clear engine. Writes occur on the rising edge. The decode stage reads it, and the writeback stage (plus the optional second writeback lane) writes it.

## Interface
Parameters:
- WIDTH, 32, data width in bits
- DEPTH, 32, number of entries; power of two, at least 2
- NRD, 2, number of read ports (1-4)
- NWR, 1, number of write ports (1-2)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- WE  in  NWR  per-port write enable
- WA  in  NWR*AW  write addresses; port p occupies bits [p*AW +: AW]; AW = log2(DEPTH)
- WD  in  NWR*WIDTH  write data, packed the same way
- RA  in  NRD*AW  read addresses, packed
- RD  out  NRD*WIDTH  read data, combinational from RA
- CLR  in  1  bulk-clear request, sampled on the rising edge
- BUSY  out  1  clear sequence in progress

## Operation
- **Storage:** DEPTH x WIDTH.
- **RST low:** all entries become 0 immediately, FSM goes to IDLE, counter = 0, BUSY = 0.
  - All RD outputs are therefore 0 during reset.
- **Write:** at a rising edge with WE[p] = 1 and BUSY = 0, mem[WA[p]] <= WD[p].
  - A write to address 0 is dropped when ZERO_REG = 1.
  - Two ports writing the same address: the higher port index wins.
- **Read:** RD[r] = mem[RA[r]]. RD[r] = 0 when ZERO_REG = 1 and RA[r] = 0.
  - Read ports are fully independent. Any number of ports may read the same address.
- **Clear FSM, IDLE:** CLR = 1 at an edge -> CLEAR, cnt = 0, BUSY = 1.
  - User writes sampled at that same edge are still performed.
- **Clear FSM, CLEAR:** at each edge mem[cnt] <= 0 and cnt increments.
  - When cnt = DEPTH-1, the last entry is cleared, the FSM returns to IDLE, cnt = 0 and BUSY = 0.
  - All user writes are dropped while BUSY = 1.
  - CLR is ignored while BUSY = 1 (no queueing).
  - Reads remain live, so partially cleared contents are visible.
- **RST mid-clear:** the sequence aborts and all state returns to reset values.
- **Address width:** the counter is AW bits. Wrap-around is never reached because termination is at DEPTH-1.

## Timing
- Read latency: 0 cycles (combinational).
- Write visibility: the next cycle without bypass, or the same cycle with bypass (see Configuration).
- BUSY rises the edge CLR is sampled in IDLE and stays high for exactly DEPTH cycles.
- Entry k is cleared at the (k+1)-th edge after the CLR sample edge.
- The first user write accepted after a clear is the one at the edge where BUSY is first sampled 0.
- There is no handshake on writes: a write is lost, not stalled, while BUSY = 1. The pipeline must stall on BUSY.

## Configuration
- **RF_BYPASS_EN defined:**
  - For each read port r, if any WE[p] = 1 with WA[p] = RA[r], BUSY = 0, and the address is not the zeroed entry 0, then RD[r] = WD of the highest-index matching port.
  - This gives same-cycle write-to-read forwarding, which replaces the old half-cycle negedge-write trick.
- **RF_BYPASS_EN undefined:**
  - RD shows stored contents only.
  - The hazard unit must cover the writeback-to-decode case with one extra stall or forward.

## Structure
- **Package rf_pkg:**
  - clear-state enum (RF_IDLE, RF_CLEAR)
  - function rf_aw(depth) returning log2
  - default WIDTH/DEPTH constants shared with the hazard unit
- **Sub-module rf_clear_seq:**
  - Holds the FSM and counter.
  - Outputs BUSY, clr_we and clr_addr.
  - The top level instantiates one rf_clear_seq and owns the storage, write arbitration and read/bypass muxes.

## Test plan
- **Reset:** hold RST low, drive arbitrary RA -> all RD = 0, BUSY = 0. Release, then write 0xDEADBEEF to 5 -> RD on RA = 5 shows 0xDEADBEEF the next cycle.
- **Zero register:** ZERO_REG = 1, write 0x1234 to 0 -> RD for RA = 0 stays 0, including the bypass path.
- **Write conflict:** NWR = 2, same cycle port0 writes 0xAAAA and port1 writes 0x5555 to 7 -> mem[7] = 0x5555. With RF_BYPASS_EN, same-cycle RD for RA = 7 = 0x5555.
- **Bypass:** write 0xCAFE to 9 while RA = 9 -> RD = 0xCAFE in the same cycle with RF_BYPASS_EN. Without it, RD shows the old value, then 0xCAFE the next cycle.
- **Clear:** fill all entries, pulse CLR -> BUSY high for exactly DEPTH cycles and entry k reads 0 after edge k+1.
  - A write to 3 during BUSY is lost.
  - A second CLR during BUSY is ignored.
- **Reset mid-clear:** at cnt = 10, assert RST -> BUSY = 0 and all entries 0 at once. After release, CLR starts a fresh DEPTH-cycle sequence.
